// File: rtl/spi_sub_if.sv
// spi_sub_if: signal bundle between the SPI subordinate and its surroundings.
// Carries the SPI pins, the result-block load strobe and the received frame
// fields.
//
// Signals:
//   sclk, cs_n, mosi   SPI inputs from the main (sclk idles low)
//   miso               SPI output to the main
//   tx_data, tx_load   result block to return and its one-cycle load strobe
//   data_out, key_out  received data block and left-aligned key
//   key_size           00 = 128-bit key, 01 = 192-bit, 10 = 256-bit
//   rx_valid           one-cycle pulse, received fields valid
//   frame_err          one-cycle pulse on abort or reserved header
//   busy               frame in progress
//
// Modports: slave (the subordinate), master (the side driving the pins).
interface spi_sub_if #(
  parameter int DATA_W    = 128,
  parameter int KEY_W_MAX = 256
);
  logic                 sclk;
  logic                 cs_n;
  logic                 mosi;
  logic                 miso;
  logic [0:DATA_W-1]    tx_data;
  logic                 tx_load;
  logic [0:DATA_W-1]    data_out;
  logic [0:KEY_W_MAX-1] key_out;
  logic [1:0]           key_size;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load,
    output miso, data_out, key_out, key_size, rx_valid, frame_err, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load,
    input  miso, data_out, key_out, key_size, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_sub.sv
// spi_sub: SPI subordinate at the AES-core end of the link.
// Oversamples sclk/cs_n/mosi in the clk domain, deframes a 2-bit key-size
// header, a DATA_W-bit data block and a 128/192/256-bit key, and at the same
// time returns the previously loaded result block on miso (bit 0 first).
//
// Ports:
//   clk    system clock, at least 8x sclk
//   reset  synchronous, active-high
//   bus    spi_sub_if.slave: SPI pins, tx_data/tx_load, data_out, key_out,
//          key_size, rx_valid and frame_err pulses, busy
//
// Build option SPI_SUB_SYNC_EN: when defined, each SPI input passes through
// SYNC_STAGES synchronizer flops ahead of the sampling flop (main asynchronous
// to clk). When undefined, inputs are registered once and the main must share
// clk.
//
// State | meaning
// IDLE  | no frame; tx_load updates the shadow register
// HDR   | receiving the 2-bit key-size code
// DATA  | receiving the data block
// KEY   | receiving the key, length taken from the header
// DONE  | one clk: publish staging registers, pulse rx_valid
// DRAIN | frame complete or bad header; sclk ignored until cs_n rises
module spi_sub #(
  parameter int DATA_W      = 128,
  parameter int KEY_W_MAX   = 256,
  parameter int SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      reset,
  spi_sub_if.slave bus
);

  localparam int KIDX_W = $clog2(KEY_W_MAX);

`ifdef SPI_SUB_SYNC_EN
  localparam int IN_STAGES = SYNC_STAGES + 1;
`else
  // SYNC_STAGES has no effect without the synchronizers.
  localparam int IN_STAGES = 1 + 0 * SYNC_STAGES;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_KEY,
    S_DONE,
    S_DRAIN
  } state_t;

  // Bit 0 takes the pin; [IN_STAGES-1] is the sampled value acted on and
  // [IN_STAGES] the previous sample, used for edge detection.
  logic [IN_STAGES:0]   sclk_pipe_q;
  logic [IN_STAGES:0]   cs_n_pipe_q;
  logic [IN_STAGES-1:0] mosi_pipe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_pipe_q <= '0;
      // Resetting cs_n low means a select that is already active when reset
      // releases never looks like a fresh fall; the main must deselect first.
      cs_n_pipe_q <= '0;
      mosi_pipe_q <= '0;
    end else begin
      sclk_pipe_q <= {sclk_pipe_q[IN_STAGES-1:0], bus.sclk};
      cs_n_pipe_q <= {cs_n_pipe_q[IN_STAGES-1:0], bus.cs_n};
      mosi_pipe_q <= (mosi_pipe_q << 1) | IN_STAGES'(bus.mosi);
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  assign sclk_rise = sclk_pipe_q[IN_STAGES-1] & ~sclk_pipe_q[IN_STAGES];
  assign sclk_fall = ~sclk_pipe_q[IN_STAGES-1] & sclk_pipe_q[IN_STAGES];
  assign cs_fall   = ~cs_n_pipe_q[IN_STAGES-1] & cs_n_pipe_q[IN_STAGES];
  assign cs_rise   = cs_n_pipe_q[IN_STAGES-1] & ~cs_n_pipe_q[IN_STAGES];
  assign mosi_s    = mosi_pipe_q[IN_STAGES-1];

  state_t               state_q, state_d;
  logic [8:0]           cnt_q, cnt_d;
  logic                 rise_seen_q, rise_seen_d;
  logic [0:DATA_W-1]    shadow_q, shadow_d;
  logic [0:DATA_W-1]    shift_q, shift_d;
  logic                 miso_q, miso_d;
  logic [1:0]           ksz_q, ksz_d;
  logic [0:DATA_W-1]    data_stg_q, data_stg_d;
  logic [0:KEY_W_MAX-1] key_stg_q, key_stg_d;
  logic [0:DATA_W-1]    data_out_q, data_out_d;
  logic [0:KEY_W_MAX-1] key_out_q, key_out_d;
  logic [1:0]           key_size_q, key_size_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  logic [8:0] cnt_inc;
  logic [8:0] key_last;

  // Saturating: a runaway sclk can never wrap the counter back into range.
  assign cnt_inc = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;

  always_comb begin
    case (ksz_q)
      2'b00:   key_last = 9'd127;
      2'b01:   key_last = 9'd191;
      default: key_last = 9'd255;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rise_seen_q <= 1'b0;
      shadow_q    <= '0;
      shift_q     <= '0;
      miso_q      <= 1'b0;
      ksz_q       <= '0;
      data_stg_q  <= '0;
      key_stg_q   <= '0;
      data_out_q  <= '0;
      key_out_q   <= '0;
      key_size_q  <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rise_seen_q <= rise_seen_d;
      shadow_q    <= shadow_d;
      shift_q     <= shift_d;
      miso_q      <= miso_d;
      ksz_q       <= ksz_d;
      data_stg_q  <= data_stg_d;
      key_stg_q   <= key_stg_d;
      data_out_q  <= data_out_d;
      key_out_q   <= key_out_d;
      key_size_q  <= key_size_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rise_seen_d = rise_seen_q;
    shadow_d    = shadow_q;
    shift_d     = shift_q;
    miso_d      = miso_q;
    ksz_d       = ksz_q;
    data_stg_d  = data_stg_q;
    key_stg_d   = key_stg_q;
    data_out_d  = data_out_q;
    key_out_d   = key_out_q;
    key_size_d  = key_size_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (bus.tx_load) begin
          shadow_d = bus.tx_data;
        end
        if (cs_fall) begin
          state_d     = S_HDR;
          cnt_d       = '0;
          rise_seen_d = 1'b0;
          // A load in the same cycle as the select goes straight out.
          shift_d     = bus.tx_load ? bus.tx_data : shadow_q;
          miso_d      = shift_d[0];
        end
      end

      S_HDR, S_DATA, S_KEY: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
          miso_d      = 1'b0;
        end else begin
          // Bit 0 is already on miso before the first rising edge, so that
          // edge does not advance the stream.
          if (sclk_rise) begin
            if (rise_seen_q) begin
              shift_d = {shift_q[1:DATA_W-1], 1'b0};
              miso_d  = shift_q[1];
            end
            rise_seen_d = 1'b1;
          end
          if (sclk_fall) begin
            case (state_q)
              S_HDR: begin
                ksz_d = {ksz_q[0], mosi_s};
                if (cnt_q == 9'd1) begin
                  cnt_d = '0;
                  if ({ksz_q[0], mosi_s} == 2'b11) begin
                    frame_err_d = 1'b1;
                    state_d     = S_DRAIN;
                    miso_d      = 1'b0;
                  end else begin
                    state_d = S_DATA;
                  end
                end else begin
                  cnt_d = cnt_inc;
                end
              end
              S_DATA: begin
                data_stg_d = {data_stg_q[1:DATA_W-1], mosi_s};
                if (cnt_q == 9'(DATA_W - 1)) begin
                  cnt_d     = '0;
                  state_d   = S_KEY;
                  key_stg_d = '0;
                end else begin
                  cnt_d = cnt_inc;
                end
              end
              default: begin
                key_stg_d[cnt_q[KIDX_W-1:0]] = mosi_s;
                if (cnt_q == key_last) begin
                  state_d = S_DONE;
                end else begin
                  cnt_d = cnt_inc;
                end
              end
            endcase
          end
        end
      end

      S_DONE: begin
        data_out_d = data_stg_q;
        key_out_d  = key_stg_q;
        key_size_d = ksz_q;
        rx_valid_d = 1'b1;
        miso_d     = 1'b0;
        state_d    = cs_rise ? S_IDLE : S_DRAIN;
      end

      S_DRAIN: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  assign bus.miso      = miso_q;
  assign bus.data_out  = data_out_q;
  assign bus.key_out   = key_out_q;
  assign bus.key_size  = key_size_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: doc/spi_sub.md
Name: spi_sub

Overview:
- SPI subordinate (responder) at the AES-core end of the link; the counterpart of the SPI main that ships key/data frames.
- Oversamples sclk, cs_n and mosi in the system clk domain.
- Deframes the 2-bit key-size header, the 128-bit data block and a 128/192/256-bit key, then presents them to the AES core.
- At the same time, shifts the previous 128-bit result out on miso (full duplex).

Parameters:
- DATA_W, 128, data/result block width in bits.
- KEY_W_MAX, 256, widest key field in bits; key_out width.
- SYNC_STAGES, 2, synchronizer flops per SPI input (used only with SPI_SUB_SYNC_EN).

Ports:
- clk  input  1  system clock; frequency ≥ 8× sclk.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from main; idles low.
- cs_n  input  1  active-low chip select from main.
- mosi  input  1  serial data from main; main changes it on sclk rising edge.
- miso  output  1  serial data to main; main samples it on sclk falling edge.
- tx_data  input  [0:DATA_W-1]  result block to return; bit 0 is sent first.
- tx_load  input  1  one-cycle strobe; captures tx_data into the shadow register.
- data_out  output  [0:DATA_W-1]  received data block; bit 0 is the first data bit received.
- key_out  output  [0:KEY_W_MAX-1]  received key, left-aligned; unused tail bits are 0.
- key_size  output  2  00 = 128-bit key, 01 = 192-bit, 10 = 256-bit.
- rx_valid  output  1  one-cycle pulse; data_out, key_out and key_size are valid.
- frame_err  output  1  one-cycle pulse on abort or reserved header.
- busy  output  1  high from cs_n fall until frame end or abort.

Behaviour:
- Reset values:
  - miso = 0, rx_valid = 0, frame_err = 0, busy = 0.
  - data_out = 0, key_out = 0, key_size = 00.
  - Shadow tx register = 0, bit counter = 0, state = IDLE.
- Edge detection: sclk and cs_n edges are detected by comparing the current sampled value with the previous one. Detection latency from pin to action, counted in clk cycles, is 1 + SYNC_STAGES with the sync option and 1 without.
- IDLE:
  - busy = 0, miso = 0.
  - tx_load updates the shadow register; tx_load is ignored while busy.
  - cs_n falling → HDR: tx shift reg ← shadow, bit counter ← 0, busy = 1, miso ← shift reg bit 0 so it is valid before the first rising edge.
- Sampling: mosi is sampled on each detected sclk falling edge.
- Drive: miso advances on each detected sclk rising edge after the first one.
- HDR: two samples form key_size.
  - Code 11 → frame_err pulse, go to DRAIN.
  - Otherwise → DATA.
- DATA: 128 samples shift into data_out staging, bit 0 first → KEY.
- KEY:
  - Accepts 128, 192 or 256 samples according to key_size.
  - Bits are written left-aligned into key staging; the tail is zeroed at entry.
  - After the last bit → DONE.
- DONE (one clk):
  - Staging registers are copied to the outputs.
  - rx_valid = 1 for exactly one cycle.
  - Go to DRAIN.
- DRAIN:
  - Ignores sclk and holds miso = 0.
  - cs_n rising → IDLE, busy = 0.
- miso stream: 128 shadow bits, then 0 for every remaining bit of the frame.
- Abort: cs_n rising in HDR, DATA or KEY → frame_err pulse, outputs unchanged, no rx_valid, → IDLE.
- Simultaneous events:
  - cs_n rise and sclk edge in the same cycle → the cs_n rise wins.
  - tx_load and cs_n fall in the same cycle → the new tx_data is sent.
- Bit counter: 9 bits wide, saturates and never wraps.
- Reset asserted mid-frame → IDLE immediately. The rest of that frame is ignored until cs_n goes high and then low again.

Optional Feature:
- Macro: SPI_SUB_SYNC_EN.
- Defined: sclk, cs_n and mosi each pass through SYNC_STAGES flops before edge detection; required when the main is asynchronous to clk.
- Undefined: inputs are registered once only; the main must share clk. Edge latency is 1 cycle. Everything else is identical.

Test Plan:
- tx_load with tx_data = 128'h0123...CDEF, then a 258-bit frame (header 00, data = 128'hA5A5...A5, key = 128'h000102...0F) → rx_valid single pulse, key_size = 00, data_out = A5..A5, key_out = {key, 128'h0}, first 128 miso bits = 0123...CDEF.
- Header 10 with a 256-bit key = 256'h00..1F → key_out exact, key_size = 10, miso = 0 after bit 128.
- Header 01 with a 192-bit key → top 192 bits of key_out match, low 64 bits = 0.
- Header 11 → frame_err pulse, no rx_valid; the remaining sclk edges are ignored until cs_n rises.
- cs_n raised after 70 data bits → frame_err pulse, outputs keep the previous frame's values, busy = 0; the next full frame decodes correctly.
- reset asserted at bit 100 → all outputs at reset values; the following clean frame decodes correctly. Repeat with SPI_SUB_SYNC_EN undefined and check 1-cycle edge latency.
